logic_result_checker: RTL
=========================

Name: logic_result_checker

Overview:
Receiving end of the logic-unit stimulus path. Samples each issued operation (A, B, S1, S0) together with the G returned by logic_unit and computes the expected result internally. Compares the two, keeps pass/fail statistics and captures the first failing operation. Sits beside logic_unit in self-checking ALU benches and in on-board BIST wrappers.

Parameters:
WIDTH, 32, operand and result width.
CNT_W, 16, width of the total, pass and fail counters.

Ports:
Clock  input  1  rising-edge clock.
Resetn  input  1  asynchronous active-low reset.
clear  input  1  synchronous clear of counters, sticky flags and pipeline.
in_valid  input  1  the A, B, S1, S0 and G inputs form one operation this cycle.
A  input  WIDTH  operand A as driven to logic_unit.
B  input  WIDTH  operand B as driven to logic_unit.
S1  input  1  function select, high bit.
S0  input  1  function select, low bit.
G  input  WIDTH  logic_unit output for this operation (combinational, same cycle).
res_valid  output  1  one-cycle pulse: a comparison result is presented.
res_pass  output  1  the presented comparison matched; qualified by res_valid.
total_count  output  CNT_W  operations checked.
pass_count  output  CNT_W  matching operations.
fail_count  output  CNT_W  mismatching operations.
fail_seen  output  1  sticky; set when any mismatch has occurred.
fail_A  output  WIDTH  captured A of the first failure.
fail_B  output  WIDTH  captured B of the first failure.
fail_sel  output  2  captured {S1,S0} of the first failure.
fail_G  output  WIDTH  captured G of the first failure.
fail_exp  output  WIDTH  captured expected value of the first failure.

Behaviour:
- Reset: Resetn low asynchronously zeroes every output and all internal registers, including the pipeline valid bits.
- Function map is {S1,S0}: 00 = A&B, 01 = A|B, 10 = A^B, 11 = ~A. B is ignored for 11.
- Stage 1 (capture): when in_valid is high, register A, B, {S1,S0} and G, and set v1. Otherwise v1 is 0.
- Stage 2 (compare): compute exp from the stage-1 operands and match = (G_r == exp). Register res_valid = v1 and res_pass = match.
- Latency: in_valid at cycle N gives res_valid at cycle N+2. Full throughput, one operation per cycle, no backpressure.
- Counters: on each res_valid, total_count increments. pass_count or fail_count increments according to match.
- Counter saturation: every counter saturates at all-ones and never wraps. When saturated, the other counters keep counting.
- First-failure capture: on the first mismatch while fail_seen is 0, load fail_A, fail_B, fail_sel, fail_G and fail_exp, and set fail_seen in the same update as res_valid. Later failures do not overwrite the capture.
- clear: takes priority over all other events in its cycle. It zeroes the counters, fail_seen and the fail_* registers, and zeroes v1 and res_valid.
  - An in_valid in the same cycle as clear is dropped.
  - Operations already in flight when clear is asserted are discarded and never counted.
- Reset asserted mid-stream: in-flight operations are lost and no partial count update occurs.
- While in_valid is low, the operand and G inputs are don't-care and must not change any state.

Decomposition:
- Shared include file logic_unit_defs.vh holds the function-select encodings: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11.
- logic_unit itself uses the same include so both ends share one encoding.
- One natural combinational sub-module, logic_unit_ref. Inputs A, B, sel; output exp. It is the golden model, instantiated in stage 2.
- Counter saturation logic stays inline in the checker.

Test Plan:
1. Reset, then four back-to-back operations with A=A5A5A5A5, B=5A5A5A5A, sel 00/01/10/11, each with a correct G (00000000, FFFFFFFF, FFFFFFFF, 5A5A5A5A).
   -> res_valid pulses at cycles 2-5 after the first in_valid, all with res_pass=1. total=4, pass=4, fail=0, fail_seen=0.
2. sel=01, A=A5A5A5A5, B=5A5A5A5A, G=00000000 injected as a fault, followed by a second fault with sel=00 and G=12345678.
   -> fail_seen=1, fail_count=2. Capture holds sel=01, fail_G=00000000, fail_exp=FFFFFFFF; the second fault does not overwrite it.
3. in_valid pulsed on cycles 0, 2 and 3, with operand garbage on the idle cycles.
   -> exactly three res_valid pulses at cycles 2, 4 and 5, and total=3.
4. clear asserted in the same cycle as in_valid, with one earlier operation still in flight.
   -> next cycle all counters and flags are 0, and no res_valid appears in the following two cycles.
5. With CNT_W=4, apply 17 passing operations.
   -> total=pass=15 (saturated) and fail=0. One failing operation then gives fail=1 with total still 15.
6. Resetn driven low asynchronously between clock edges while operations are in flight.
   -> all outputs go to 0 immediately, and no res_valid appears after Resetn is released.

Source files
------------

// File: rtl/logic_result_checker_pkg.sv
// Shared definitions for the logic-unit checking path: the function-select
// encoding used by both logic_unit and its checker.
package logic_result_checker_pkg;

  // {S1,S0} function select encoding shared by stimulus and golden model.
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  localparam int SEL_W = 2;

endpackage

// File: rtl/logic_result_checker_ref.sv
// Golden model of logic_unit: purely combinational result for one operation.
module logic_unit_ref
  import logic_result_checker_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] exp
);

  // Decode the function select into the expected logic result; B unused for NOT.
  always_comb begin
    exp = '0;
    case (sel)
      OP_AND:  exp = A & B;
      OP_OR:   exp = A | B;
      OP_XOR:  exp = A ^ B;
      OP_NOT:  exp = ~A;
      default: exp = '0;
    endcase
  end

endmodule

// File: rtl/logic_result_checker.sv
// Two-stage checker: captures each issued logic-unit operation, compares the
// returned G against the golden model, and keeps saturating statistics plus a
// snapshot of the first failing operation.
module logic_result_checker
  import logic_result_checker_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S1,
  input  logic             S0,
  input  logic [WIDTH-1:0] G,
  output logic             res_valid,
  output logic             res_pass,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             fail_seen,
  output logic [WIDTH-1:0] fail_A,
  output logic [WIDTH-1:0] fail_B,
  output logic [1:0]       fail_sel,
  output logic [WIDTH-1:0] fail_G,
  output logic [WIDTH-1:0] fail_exp
);

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [SEL_W-1:0] sel_p1;
  logic [WIDTH-1:0] g_p1;
  logic [WIDTH-1:0] exp_p1;
  logic             match_p1;

  // ---- stage 1: capture the issued operation and the returned G ----
  // Operand registers load only on a valid, uncleared operation so idle-cycle
  // garbage on the inputs never disturbs state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      sel_p1 <= '0;
      g_p1   <= '0;
    end else if (clear) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        a_p1   <= A;
        b_p1   <= B;
        sel_p1 <= {S1, S0};
        g_p1   <= G;
      end
    end
  end

  logic_unit_ref #(.WIDTH(WIDTH)) u_ref (
    .A   (a_p1),
    .B   (b_p1),
    .sel (sel_p1),
    .exp (exp_p1)
  );

  assign match_p1 = (g_p1 == exp_p1);

  // ---- stage 2: present the comparison and update statistics ----
  // Counters and first-failure capture update on the same edge that raises
  // res_valid, so they are already consistent while the pulse is visible.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      res_valid   <= 1'b0;
      res_pass    <= 1'b0;
      total_count <= '0;
      pass_count  <= '0;
      fail_count  <= '0;
      fail_seen   <= 1'b0;
      fail_A      <= '0;
      fail_B      <= '0;
      fail_sel    <= '0;
      fail_G      <= '0;
      fail_exp    <= '0;
    end else if (clear) begin
      res_valid   <= 1'b0;
      res_pass    <= 1'b0;
      total_count <= '0;
      pass_count  <= '0;
      fail_count  <= '0;
      fail_seen   <= 1'b0;
      fail_A      <= '0;
      fail_B      <= '0;
      fail_sel    <= '0;
      fail_G      <= '0;
      fail_exp    <= '0;
    end else begin
      res_valid <= vld_p1;
      if (vld_p1) begin
        res_pass    <= match_p1;
        total_count <= sat_inc(total_count);
        if (match_p1) begin
          pass_count <= sat_inc(pass_count);
        end else begin
          fail_count <= sat_inc(fail_count);
          if (!fail_seen) begin
            fail_seen <= 1'b1;
            fail_A    <= a_p1;
            fail_B    <= b_p1;
            fail_sel  <= sel_p1;
            fail_G    <= g_p1;
            fail_exp  <= exp_p1;
          end
        end
      end
    end
  end

endmodule
